// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch timekeeping stage.
// Holds the FSM state encoding and the BCD digit widths/limits. The display
// interface uses the same digit widths, so both sides stay consistent.

package stopwatch_counter_pkg;

    // Run-control states; encodings are fixed so the display side can decode them.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } sw_state_e;

    localparam int unsigned NUM_1S_W  = 4;
    localparam int unsigned NUM_10S_W = 3;

    localparam logic [NUM_1S_W-1:0]  SEC_1S_MAX  = 4'd9;
    localparam logic [NUM_10S_W-1:0] SEC_10S_MAX = 3'd5;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Button/display bundle of the stopwatch timekeeping stage.
//   btn_start  raw async start/pause button, active-high
//   btn_clr    raw async clear button, active-high
//   num_1s     seconds units, BCD 0..9
//   num_10s    seconds tens, 0..5
//   running    1 while counting
//   wrap       one-cycle pulse on the 59 -> 00 increment
// master: the buttons/display side. slave: the stopwatch_counter.

interface stopwatch_counter_if;

    logic                                         btn_start;
    logic                                         btn_clr;
    logic [stopwatch_counter_pkg::NUM_1S_W-1:0]   num_1s;
    logic [stopwatch_counter_pkg::NUM_10S_W-1:0]  num_10s;
    logic                                         running;
    logic                                         wrap;

    modport master (
        output btn_start,
        output btn_clr,
        input  num_1s,
        input  num_10s,
        input  running,
        input  wrap
    );

    modport slave (
        input  btn_start,
        input  btn_clr,
        output num_1s,
        output num_10s,
        output running,
        output wrap
    );

endinterface

// File: rtl/stopwatch_counter_btn_cond.sv
// Button conditioner (btn_cond): 2-FF synchronizer, debounce and rising-edge
// detect for one raw asynchronous push button.
//   clk     system clock
//   rst     asynchronous, active-high reset
//   btn_in  raw button level, active-high
//   press   one-cycle pulse per accepted press (registered)
// The accepted level only follows the synced input after DEBOUNCE_CYC
// consecutive cycles of the new value. Pin rise sampled at edge k gives a
// press pulse in the cycle after edge k+1+DEBOUNCE_CYC.

module stopwatch_counter_btn_cond #(
    parameter int unsigned DEBOUNCE_CYC = 1_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                // Any sample agreeing with the accepted level restarts the run.
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                // This is the DEBOUNCE_CYC-th consecutive differing sample.
                cnt_q   <= '0;
                level_q <= sync2_q;
                press_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping stage: conditions the start/clear buttons, divides
// clk into a 1 s tick and keeps a BCD seconds count 00..59.
//   clk   system clock (CLK_FREQ cycles per counted second)
//   rst   asynchronous, active-high reset
//   bus   stopwatch_counter_if.slave: btn_start, btn_clr in;
//         num_1s, num_10s, running, wrap out
// Start toggles run/pause, clear returns to 00 and stops; clear wins over a
// simultaneous start.

module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 125_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_250_000
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_counter_if.slave   bus
);

    localparam int unsigned PrescW = $clog2(CLK_FREQ);
    localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_FREQ - 1);

    logic start_press;
    logic clr_press;

    sw_state_e              state_q;
    logic                   running_q;
    logic [PrescW-1:0]      presc_q;
    logic [NUM_1S_W-1:0]    ones_q;
    logic [NUM_10S_W-1:0]   tens_q;
    logic                   wrap_q;

    stopwatch_counter_btn_cond #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_start (
        .clk    (clk),
        .rst    (rst),
        .btn_in (bus.btn_start),
        .press  (start_press)
    );

    stopwatch_counter_btn_cond #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_clr (
        .clk    (clk),
        .rst    (rst),
        .btn_in (bus.btn_clr),
        .press  (clr_press)
    );

    // Run-control FSM; running is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
        end else if (clr_press) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
        end else if (start_press) begin
            unique case (state_q)
                StIdle, StPause: begin
                    state_q   <= StRun;
                    running_q <= 1'b1;
                end
                StRun: begin
                    state_q   <= StPause;
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler and BCD seconds. The prescaler holds through a pause so a
    // resume finishes the partial second; the digits move only on the tick
    // or on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (clr_press) begin
                presc_q <= '0;
                ones_q  <= '0;
                tens_q  <= '0;
            end else if (state_q == StIdle) begin
                presc_q <= '0;
            end else if (state_q == StRun) begin
                if (presc_q >= PrescMax) begin
                    presc_q <= '0;
                    if (ones_q >= SEC_1S_MAX) begin
                        ones_q <= '0;
                        if (tens_q >= SEC_10S_MAX) begin
                            tens_q <= '0;
                            wrap_q <= 1'b1;
                        end else begin
                            tens_q <= tens_q + 1'b1;
                        end
                    end else begin
                        ones_q <= ones_q + 1'b1;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign bus.num_1s  = ones_q;
    assign bus.num_10s = tens_q;
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with CLK_FREQ=5, DEBOUNCE_CYC=3.
// Inputs are driven and outputs sampled on the falling clock edge; "t" in the
// comments counts rising edges after the edge on which RUN was entered.

module tb_stopwatch_counter;

    localparam int unsigned ClkFreq = 5;
    localparam int unsigned DebCyc  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .CLK_FREQ     (ClkFreq),
        .DEBOUNCE_CYC (DebCyc)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sw_if.btn_start = 1'b0;
        sw_if.btn_clr   = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    // Press start; returns at the falling edge right after RUN is entered (t=0).
    task automatic start_run();
        sw_if.btn_start = 1'b1;
        step(6);
        sw_if.btn_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw_if.btn_start = 1'b0;
        sw_if.btn_clr   = 1'b0;
        step(20);
        tests_run++;
        if (sw_if.num_1s !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_num_1s: got %0d want 0", sw_if.num_1s);
        end
        tests_run++;
        if (sw_if.num_10s !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_num_10s: got %0d want 0", sw_if.num_10s);
        end
        tests_run++;
        if (sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_running: got %b want 0", sw_if.running);
        end
        tests_run++;
        if (sw_if.wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wrap: got %b want 0", sw_if.wrap);
        end
        rst = 1'b0;
        step(10);
        tests_run++;
        if (sw_if.running !== 1'b0 || sw_if.num_1s !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got run=%b ones=%0d want run=0 ones=0",
                     sw_if.running, sw_if.num_1s);
        end
    endtask

    task automatic test_start();
        sw_if.btn_start = 1'b1;
        step(5);
        tests_run++;
        if (sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_latency_early: got running=%b want 0", sw_if.running);
        end
        step(1);  // t=0
        tests_run++;
        if (sw_if.running !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_latency: got running=%b want 1", sw_if.running);
        end
        step(4);  // t=4, button held 10 cycles in total
        sw_if.btn_start = 1'b0;
        tests_run++;
        if (sw_if.num_1s !== 4'd0) begin
            tests_failed++;
            $display("FAIL start_first_tick_early: got num_1s=%0d want 0", sw_if.num_1s);
        end
        step(1);  // t=5
        tests_run++;
        if (sw_if.num_1s !== 4'd1 || sw_if.num_10s !== 3'd0) begin
            tests_failed++;
            $display("FAIL start_first_tick: got %0d%0d want 01", sw_if.num_10s, sw_if.num_1s);
        end
        step(5);  // t=10
        tests_run++;
        if (sw_if.running !== 1'b1 || sw_if.num_1s !== 4'd2) begin
            tests_failed++;
            $display("FAIL start_hold_single_press: got run=%b ones=%0d want run=1 ones=2",
                     sw_if.running, sw_if.num_1s);
        end
        step(40); // t=50
        tests_run++;
        if (sw_if.num_10s !== 3'd1 || sw_if.num_1s !== 4'd0) begin
            tests_failed++;
            $display("FAIL start_carry_10: got %0d%0d want 10", sw_if.num_10s, sw_if.num_1s);
        end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        #1;
        tests_run++;
        if (sw_if.num_1s !== 4'd0 || sw_if.num_10s !== 3'd0 || sw_if.running !== 1'b0 ||
            sw_if.wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got %0d%0d run=%b wrap=%b want 00 run=0 wrap=0",
                     sw_if.num_10s, sw_if.num_1s, sw_if.running, sw_if.wrap);
        end
        step(1);
        tests_run++;
        if (sw_if.num_1s !== 4'd0 || sw_if.num_10s !== 3'd0 || sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: got %0d%0d run=%b want 00 run=0",
                     sw_if.num_10s, sw_if.num_1s, sw_if.running);
        end
        rst = 1'b0;
        step(10);
        tests_run++;
        if (sw_if.running !== 1'b0 || sw_if.num_1s !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_run_release: got run=%b ones=%0d want run=0 ones=0",
                     sw_if.running, sw_if.num_1s);
        end
    endtask

    task automatic test_wrap();
        int wraps;
        wraps = 0;
        apply_reset();
        start_run();
        tests_run++;
        if (sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd0 || sw_if.running !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_start_00: got %0d%0d run=%b want 00 run=1",
                     sw_if.num_10s, sw_if.num_1s, sw_if.running);
        end
        for (int t = 1; t <= 305; t++) begin
            step(1);
            if (sw_if.wrap === 1'b1) wraps++;
            if (t == 299) begin
                tests_run++;
                if (sw_if.num_10s !== 3'd5 || sw_if.num_1s !== 4'd9 || sw_if.wrap !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL wrap_59: got %0d%0d wrap=%b want 59 wrap=0",
                             sw_if.num_10s, sw_if.num_1s, sw_if.wrap);
                end
            end
            if (t == 300) begin
                tests_run++;
                if (sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd0 || sw_if.wrap !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL wrap_00: got %0d%0d wrap=%b want 00 wrap=1",
                             sw_if.num_10s, sw_if.num_1s, sw_if.wrap);
                end
            end
            if (t == 301) begin
                tests_run++;
                if (sw_if.num_1s !== 4'd0 || sw_if.wrap !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL wrap_pulse_width: got ones=%0d wrap=%b want ones=0 wrap=0",
                             sw_if.num_1s, sw_if.wrap);
                end
            end
            if (t == 305) begin
                tests_run++;
                if (sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd1 || sw_if.running !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL wrap_continue: got %0d%0d run=%b want 01 run=1",
                             sw_if.num_10s, sw_if.num_1s, sw_if.running);
                end
            end
        end
        tests_run++;
        if (wraps !== 1) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d pulses want 1", wraps);
        end
    endtask

    task automatic test_pause_resume();
        apply_reset();
        start_run();
        step(32);  // t=32
        tests_run++;
        if (sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd6) begin
            tests_failed++;
            $display("FAIL pause_pre_06: got %0d%0d want 06", sw_if.num_10s, sw_if.num_1s);
        end
        sw_if.btn_start = 1'b1;
        step(5);   // t=37
        tests_run++;
        if (sw_if.running !== 1'b1 || sw_if.num_1s !== 4'd7) begin
            tests_failed++;
            $display("FAIL pause_pre_07: got run=%b ones=%0d want run=1 ones=7",
                     sw_if.running, sw_if.num_1s);
        end
        step(1);   // t=38, prescaler holds at 3
        tests_run++;
        if (sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_enter: got running=%b want 0", sw_if.running);
        end
        step(3);
        sw_if.btn_start = 1'b0;
        step(37);  // t=78, 40 cycles paused
        tests_run++;
        if (sw_if.running !== 1'b0 || sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd7) begin
            tests_failed++;
            $display("FAIL pause_hold: got %0d%0d run=%b want 07 run=0",
                     sw_if.num_10s, sw_if.num_1s, sw_if.running);
        end
        sw_if.btn_start = 1'b1;
        step(6);   // t=84
        tests_run++;
        if (sw_if.running !== 1'b1 || sw_if.num_1s !== 4'd7) begin
            tests_failed++;
            $display("FAIL resume_enter: got run=%b ones=%0d want run=1 ones=7",
                     sw_if.running, sw_if.num_1s);
        end
        step(1);
        tests_run++;
        if (sw_if.num_1s !== 4'd7) begin
            tests_failed++;
            $display("FAIL resume_partial_early: got ones=%0d want 7", sw_if.num_1s);
        end
        step(1);
        tests_run++;
        if (sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd8) begin
            tests_failed++;
            $display("FAIL resume_partial: got %0d%0d want 08", sw_if.num_10s, sw_if.num_1s);
        end
        sw_if.btn_start = 1'b0;
    endtask

    task automatic test_clear();
        apply_reset();
        start_run();
        step(210);  // t=210
        tests_run++;
        if (sw_if.num_10s !== 3'd4 || sw_if.num_1s !== 4'd2) begin
            tests_failed++;
            $display("FAIL clear_pre_42: got %0d%0d want 42", sw_if.num_10s, sw_if.num_1s);
        end
        sw_if.btn_clr = 1'b1;
        step(5);    // t=215
        tests_run++;
        if (sw_if.num_10s !== 3'd4 || sw_if.num_1s !== 4'd3 || sw_if.running !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_pre_43: got %0d%0d run=%b want 43 run=1",
                     sw_if.num_10s, sw_if.num_1s, sw_if.running);
        end
        step(1);    // t=216
        tests_run++;
        if (sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd0 || sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_run: got %0d%0d run=%b want 00 run=0",
                     sw_if.num_10s, sw_if.num_1s, sw_if.running);
        end
        step(4);
        sw_if.btn_clr = 1'b0;
        step(10);
        tests_run++;
        if (sw_if.num_1s !== 4'd0 || sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_stays_idle: got run=%b ones=%0d want run=0 ones=0",
                     sw_if.running, sw_if.num_1s);
        end
        // Start and clear together while running: clear must win.
        start_run();
        step(12);   // t=12
        tests_run++;
        if (sw_if.num_1s !== 4'd2 || sw_if.running !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_start_pre_02: got run=%b ones=%0d want run=1 ones=2",
                     sw_if.running, sw_if.num_1s);
        end
        sw_if.btn_start = 1'b1;
        sw_if.btn_clr   = 1'b1;
        step(6);
        tests_run++;
        if (sw_if.num_10s !== 3'd0 || sw_if.num_1s !== 4'd0 || sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_start_from_run: got %0d%0d run=%b want 00 run=0",
                     sw_if.num_10s, sw_if.num_1s, sw_if.running);
        end
        step(4);
        sw_if.btn_start = 1'b0;
        sw_if.btn_clr   = 1'b0;
        step(10);
        // Same again from IDLE: start alone would enter RUN.
        sw_if.btn_start = 1'b1;
        sw_if.btn_clr   = 1'b1;
        step(6);
        tests_run++;
        if (sw_if.running !== 1'b0 || sw_if.num_1s !== 4'd0) begin
            tests_failed++;
            $display("FAIL clr_start_from_idle: got run=%b ones=%0d want run=0 ones=0",
                     sw_if.running, sw_if.num_1s);
        end
        step(4);
        sw_if.btn_start = 1'b0;
        sw_if.btn_clr   = 1'b0;
        step(10);
    endtask

    task automatic test_bounce();
        // Two-cycle glitch is one sample short of acceptance.
        sw_if.btn_start = 1'b1;
        step(2);
        sw_if.btn_start = 1'b0;
        step(8);
        tests_run++;
        if (sw_if.running !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_glitch: got running=%b want 0", sw_if.running);
        end
        for (int i = 0; i < 4; i++) begin
            sw_if.btn_start = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(1);
        end
        sw_if.btn_start = 1'b0;
        step(10);
        tests_run++;
        if (sw_if.running !== 1'b0 || sw_if.num_1s !== 4'd0) begin
            tests_failed++;
            $display("FAIL bounce_chatter: got run=%b ones=%0d want run=0 ones=0",
                     sw_if.running, sw_if.num_1s);
        end
        // Exactly DEBOUNCE_CYC cycles high is the shortest accepted press.
        sw_if.btn_start = 1'b1;
        step(3);
        sw_if.btn_start = 1'b0;
        step(3);
        tests_run++;
        if (sw_if.running !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounce_min_press: got running=%b want 1", sw_if.running);
        end
    endtask

    initial begin
        sw_if.btn_start = 1'b0;
        sw_if.btn_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_start();
        test_reset_mid_run();
        test_wrap();
        test_pause_resume();
        test_clear();
        test_bounce();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
